// File: rtl/rtc_bus_scheduler_pkg.sv
// rtc_bus_scheduler_pkg: shared V3023 register map, burst FSM states and helpers
// for the RTC bus scheduler and the display/setting logic.
package rtc_bus_scheduler_pkg;

    localparam int          DEF_NUM_REGS     = 7;
    localparam logic [7:0]  DEF_BASE_ADDR    = 8'h21;
    localparam logic [7:0]  DEF_XFER_WR_ADDR = 8'hF0;
    localparam logic [7:0]  DEF_XFER_RD_ADDR = 8'hF1;
    localparam logic [15:0] DEF_TIMEOUT_CYC  = 16'd60000;

    typedef enum logic [3:0] {
        IDLE, W_ISSUE, W_WAIT, WX_ISSUE, WX_WAIT,
        RX_ISSUE, RX_WAIT, R_ISSUE, R_WAIT, R_DONE
    } state_t;

    function automatic logic is_wait(input state_t s);
        return s inside {W_WAIT, WX_WAIT, RX_WAIT, R_WAIT};
    endfunction

endpackage

// File: rtl/rtc_bus_scheduler_if.sv
// rtc_bus_scheduler_if: start/finish handshake and address/data lines between
// the burst scheduler and the single-access bus cycle engines.
interface rtc_bus_scheduler_if;

    logic       eng_start_wr;
    logic       eng_start_rd;
    logic [7:0] bus_addr;
    logic [7:0] bus_wdata;
    logic       eng_fin;
    logic [7:0] eng_rdata;

    modport master (
        output eng_start_wr, eng_start_rd, bus_addr, bus_wdata,
        input  eng_fin, eng_rdata
    );

    modport slave (
        input  eng_start_wr, eng_start_rd, bus_addr, bus_wdata,
        output eng_fin, eng_rdata
    );

endinterface

// File: rtl/rtc_bus_scheduler_watchdog.sv
// rtc_watchdog: per-access timeout counter; pulses expire for one cycle on the
// TIMEOUT_CYC-th enabled cycle since the last clear.
module rtc_watchdog #(
    parameter logic [15:0] TIMEOUT_CYC = 16'd60000
) (
    input  logic Clock_in,
    input  logic Reset,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    logic [15:0] r_cnt;

    assign expire = enable && (r_cnt == TIMEOUT_CYC - 16'd1);

    always_ff @(posedge Clock_in) begin
        if (Reset || clear)
            r_cnt <= '0;
        else if (enable)
            r_cnt <= expire ? '0 : r_cnt + 16'd1;
    end

endmodule

// File: rtl/rtc_bus_scheduler.sv
// rtc_bus_scheduler: sequences write/read register bursts on the V3023 RTC bus,
// arbitrating user time-set requests against periodic read-back ticks.
module rtc_bus_scheduler
    import rtc_bus_scheduler_pkg::*;
#(
    parameter int          NUM_REGS     = DEF_NUM_REGS,
    parameter logic [7:0]  BASE_ADDR    = DEF_BASE_ADDR,
    parameter logic [7:0]  XFER_WR_ADDR = DEF_XFER_WR_ADDR,
    parameter logic [7:0]  XFER_RD_ADDR = DEF_XFER_RD_ADDR,
    parameter logic [15:0] TIMEOUT_CYC  = DEF_TIMEOUT_CYC
) (
    input  logic                  Clock_in,
    input  logic                  Reset,
    input  logic                  wr_req,
    input  logic [8*NUM_REGS-1:0] wr_image,
    input  logic                  rd_tick,
    output logic [8*NUM_REGS-1:0] rd_image,
    output logic                  rd_valid,
    output logic                  wr_done,
    output logic                  busy,
    output logic                  timeout_err,
    rtc_bus_scheduler_if.master   bus
);

    localparam int IW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [IW-1:0] LAST = IW'(NUM_REGS - 1);

    state_t                r_state, w_next;
    logic [IW-1:0]         r_idx, w_idx;
    logic                  r_wr_pend, r_rd_pend;
    logic [8*NUM_REGS-1:0] r_shadow, r_stage, r_rd_image;
    logic                  r_start_wr, r_start_rd, r_rd_valid, r_wr_done, r_busy, r_timeout;
    logic [7:0]            r_addr, r_wdata, w_addr, w_wdata;
    logic                  w_wait, w_fin, w_expire, w_abort;

    assign w_wait  = is_wait(r_state);
    assign w_fin   = w_wait && bus.eng_fin;
    assign w_abort = w_wait && !bus.eng_fin && w_expire;

    rtc_watchdog #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_wd (
        .Clock_in (Clock_in),
        .Reset    (Reset),
        .clear    (!w_wait),
        .enable   (w_wait),
        .expire   (w_expire)
    );

    always_comb begin
        w_next = r_state;
        w_idx  = r_idx;
        case (r_state)
            IDLE: begin
                w_next = r_wr_pend ? W_ISSUE : r_rd_pend ? RX_ISSUE : IDLE;
                w_idx  = '0;
            end
            W_ISSUE:  w_next = W_WAIT;
            W_WAIT: if (w_fin) begin
                w_next = (r_idx == LAST) ? WX_ISSUE : W_ISSUE;
                w_idx  = (r_idx == LAST) ? r_idx : r_idx + 1'b1;
            end
            WX_ISSUE: w_next = WX_WAIT;
            WX_WAIT:  w_next = w_fin ? IDLE : WX_WAIT;
            RX_ISSUE: w_next = RX_WAIT;
            RX_WAIT: if (w_fin) begin
                w_next = R_ISSUE;
                w_idx  = '0;
            end
            R_ISSUE:  w_next = R_WAIT;
            R_WAIT: if (w_fin) begin
                w_next = (r_idx == LAST) ? R_DONE : R_ISSUE;
                w_idx  = (r_idx == LAST) ? r_idx : r_idx + 1'b1;
            end
            default:  w_next = IDLE;
        endcase
        if (w_abort) w_next = IDLE;
        // Address/data are loaded only on entry to an ISSUE state, then held through the wait.
        w_addr  = (w_next == W_ISSUE || w_next == R_ISSUE) ? BASE_ADDR + 8'(w_idx) :
                  (w_next == WX_ISSUE) ? XFER_WR_ADDR :
                  (w_next == RX_ISSUE) ? XFER_RD_ADDR : r_addr;
        w_wdata = (w_next == W_ISSUE) ? r_shadow[8*w_idx +: 8] :
                  (w_next == WX_ISSUE || w_next == RX_ISSUE) ? 8'h00 : r_wdata;
    end

    always_ff @(posedge Clock_in) begin
        if (Reset) begin
            r_state    <= IDLE;
            r_idx      <= '0;
            r_wr_pend  <= 1'b0;
            r_rd_pend  <= 1'b0;
            r_shadow   <= '0;
            r_stage    <= '0;
            r_rd_image <= '0;
            r_start_wr <= 1'b0;
            r_start_rd <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_rd_valid <= 1'b0;
            r_wr_done  <= 1'b0;
            r_busy     <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_idx      <= w_idx;
            r_wr_pend  <= wr_req  || (r_wr_pend && !(r_state == IDLE && w_next == W_ISSUE));
            r_rd_pend  <= rd_tick || (r_rd_pend && !(r_state == IDLE && w_next == RX_ISSUE));
            if (wr_req) r_shadow <= wr_image;
            if (r_state == R_WAIT && w_fin) r_stage[8*r_idx +: 8] <= bus.eng_rdata;
            if (r_state == R_DONE) r_rd_image <= r_stage;
            r_start_wr <= w_next inside {W_ISSUE, WX_ISSUE, RX_ISSUE};
            r_start_rd <= w_next == R_ISSUE;
            r_addr     <= w_addr;
            r_wdata    <= w_wdata;
            r_rd_valid <= r_state == R_DONE;
            r_wr_done  <= r_state == WX_WAIT && w_fin;
            r_busy     <= w_next != IDLE;
            r_timeout  <= r_timeout || w_abort;
        end
    end

    assign bus.eng_start_wr = r_start_wr;
    assign bus.eng_start_rd = r_start_rd;
    assign bus.bus_addr     = r_addr;
    assign bus.bus_wdata    = r_wdata;
    assign rd_image         = r_rd_image;
    assign rd_valid         = r_rd_valid;
    assign wr_done          = r_wr_done;
    assign busy             = r_busy;
    assign timeout_err      = r_timeout;

endmodule

// File: tb/tb_rtc_bus_scheduler.sv
// tb_rtc_bus_scheduler: scoreboard bench with a cycle-engine model answering
// each start pulse 20 cycles later; expected accesses/images are queued up front.
module tb_rtc_bus_scheduler;

    logic        Clock_in = 1'b0;
    logic        Reset    = 1'b1;
    logic        wr_req   = 1'b0;
    logic        rd_tick  = 1'b0;
    logic [55:0] wr_image = '0;
    logic [55:0] rd_image;
    logic        rd_valid, wr_done, busy, timeout_err;

    rtc_bus_scheduler_if bus ();

    rtc_bus_scheduler #(.TIMEOUT_CYC(16'd100)) dut (
        .Clock_in    (Clock_in),
        .Reset       (Reset),
        .wr_req      (wr_req),
        .wr_image    (wr_image),
        .rd_tick     (rd_tick),
        .rd_image    (rd_image),
        .rd_valid    (rd_valid),
        .wr_done     (wr_done),
        .busy        (busy),
        .timeout_err (timeout_err),
        .bus         (bus)
    );

    always #5 Clock_in = ~Clock_in;

    int total = 0, bad = 0, cyc = 0;
    int n_starts = 0, n_wd = 0, wd_cyc = 0, f1_cyc = 0, st_cyc = 0, exp_wd = 0;
    int ecnt = 0;
    logic        e_rd = 1'b0;
    logic [7:0]  hold_addr = 8'h00;
    logic [16:0] exp_acc[$];
    logic [7:0]  rdq[$];
    logic [55:0] exp_img[$];

    always @(posedge Clock_in) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic exp_write(input logic [55:0] img);
        for (int k = 0; k < 7; k++) exp_acc.push_back({1'b0, 8'(8'h21 + k), img[8*k +: 8]});
        exp_acc.push_back({1'b0, 8'hF0, 8'h00});
        exp_wd++;
    endtask

    task automatic exp_read(input logic [55:0] img);
        exp_acc.push_back({1'b0, 8'hF1, 8'h00});
        for (int k = 0; k < 7; k++) begin
            exp_acc.push_back({1'b1, 8'(8'h21 + k), 8'h00});
            rdq.push_back(img[8*k +: 8]);
        end
        exp_img.push_back(img);
    endtask

    task automatic pulse(input logic w, input logic r, input logic [55:0] img);
        @(negedge Clock_in);
        wr_req = w; rd_tick = r; wr_image = img;
        @(negedge Clock_in);
        wr_req = 1'b0; rd_tick = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        do begin
            @(negedge Clock_in);
            n++;
        end while (n < 4000 && (busy || exp_acc.size() > 0 || exp_img.size() > 0 || exp_wd > 0));
        chk({name, "_done_in_bound"}, 64'(n < 4000), 1);
    endtask

    task automatic wait_starts(input int target);
        int n = 0;
        while (n_starts < target && n < 2000) begin
            @(negedge Clock_in);
            n++;
        end
        chk("start_wait_bound", 64'(n_starts >= target), 1);
    endtask

    task automatic chk_zero_outputs(input string name);
        chk(name, {bus.eng_start_wr, bus.eng_start_rd, bus.bus_addr, bus.bus_wdata,
                   rd_valid, wr_done, busy, timeout_err}, 0);
        chk({name, "_image"}, rd_image, 0);
    endtask

    // Engine model: eng_fin 20 cycles after each start; hold_addr read is never answered.
    initial begin
        bus.eng_fin   = 1'b0;
        bus.eng_rdata = 8'h00;
        forever begin
            @(negedge Clock_in);
            bus.eng_fin = 1'b0;
            if (Reset) ecnt = 0;
            else if (bus.eng_start_wr || bus.eng_start_rd) begin
                e_rd = bus.eng_start_rd;
                ecnt = (e_rd && bus.bus_addr == hold_addr) ? 0 : 20;
            end else if (ecnt > 0) begin
                ecnt--;
                if (ecnt == 0) begin
                    bus.eng_fin   = 1'b1;
                    bus.eng_rdata = (e_rd && rdq.size() > 0) ? rdq.pop_front() : 8'h00;
                end
            end
        end
    end

    // Monitor: scores every start pulse, wr_done and rd_valid against the queues.
    initial forever begin
        @(negedge Clock_in);
        if (bus.eng_start_wr || bus.eng_start_rd) begin
            n_starts++;
            st_cyc = cyc;
            if (bus.eng_start_wr && bus.bus_addr == 8'hF1) f1_cyc = cyc;
            if (exp_acc.size() == 0) chk("start_unexpected", {bus.eng_start_wr, bus.eng_start_rd}, 0);
            else chk("access", {bus.eng_start_rd, bus.bus_addr, bus.eng_start_rd ? 8'h00 : bus.bus_wdata},
                     exp_acc.pop_front());
        end
        if (wr_done) begin
            n_wd++;
            wd_cyc = cyc;
            if (exp_wd == 0) chk("wr_done_unexpected", wr_done, 0);
            else exp_wd--;
        end
        if (rd_valid) begin
            if (exp_img.size() == 0) chk("rd_valid_unexpected", rd_valid, 0);
            else chk("rd_image", rd_image, exp_img.pop_front());
        end
    end

    initial begin
        int n0, w0, lo, n, to_cyc;
        repeat (3) @(negedge Clock_in);
        chk_zero_outputs("reset_outputs");
        Reset = 1'b0;

        // Write burst, busy held high from first start to wr_done
        exp_write(56'h01_26_05_14_12_30_00);
        n0 = n_starts; w0 = n_wd; lo = 0; n = 0;
        pulse(1'b1, 1'b0, 56'h01_26_05_14_12_30_00);
        wait_starts(n0 + 1);
        while (n_wd == w0 && n < 1000) begin
            if (!busy) lo++;
            @(negedge Clock_in);
            n++;
        end
        chk("busy_during_write", lo, 0);
        wait_idle("write");
        chk("wr_done_count", n_wd - w0, 1);

        // Read burst
        exp_read(56'h06_99_12_31_23_59_45);
        pulse(1'b0, 1'b1, '0);
        wait_idle("read");
        chk("rd_image_held", rd_image, 56'h06_99_12_31_23_59_45);

        // Simultaneous request: write first, read one cycle after wr_done
        exp_write(56'h02_27_06_15_13_31_01);
        exp_read(56'h07_60_50_40_30_20_10);
        pulse(1'b1, 1'b1, 56'h02_27_06_15_13_31_01);
        wait_idle("simultaneous");
        chk("simul_read_gap", f1_cyc - wd_cyc, 1);

        // rd_tick mid write burst stays pending
        exp_write(56'h03_28_07_16_14_32_02);
        exp_read(56'h01_02_03_04_05_06_07);
        n0 = n_starts;
        pulse(1'b1, 1'b0, 56'h03_28_07_16_14_32_02);
        wait_starts(n0 + 3);
        pulse(1'b0, 1'b1, '0);
        wait_idle("midburst");
        chk("mid_read_gap", f1_cyc - wd_cyc, 1);

        // Timeout on the third read
        hold_addr = 8'h23;
        exp_acc.push_back({1'b0, 8'hF1, 8'h00});
        for (int k = 0; k < 3; k++) exp_acc.push_back({1'b1, 8'(8'h21 + k), 8'h00});
        rdq.push_back(8'h11);
        rdq.push_back(8'h22);
        pulse(1'b0, 1'b1, '0);
        n = 0;
        while (!timeout_err && n < 1000) begin
            @(negedge Clock_in);
            n++;
        end
        to_cyc = cyc;
        chk("timeout_seen", timeout_err, 1);
        chk("timeout_latency", to_cyc - st_cyc, 101);
        chk("timeout_idle", busy, 0);
        chk("timeout_image", rd_image, 56'h01_02_03_04_05_06_07);
        repeat (30) @(negedge Clock_in);
        chk("timeout_sticky", timeout_err, 1);
        chk("timeout_no_restart", busy, 0);
        hold_addr = 8'h00;
        rdq.delete();
        wait_idle("timeout");

        // Reset in W_WAIT abandons the burst; a fresh request restarts at 0x21
        exp_acc.push_back({1'b0, 8'h21, 8'h10});
        exp_acc.push_back({1'b0, 8'h22, 8'h20});
        n0 = n_starts;
        pulse(1'b1, 1'b0, 56'h70_60_50_40_30_20_10);
        wait_starts(n0 + 2);
        repeat (5) @(negedge Clock_in);
        Reset = 1'b1;
        @(negedge Clock_in);
        chk_zero_outputs("midburst_reset");
        @(negedge Clock_in);
        Reset = 1'b0;
        chk("reset_queue_drained", exp_acc.size(), 0);
        repeat (40) @(negedge Clock_in);
        chk("reset_no_restart", busy, 0);
        exp_write(56'h09_08_07_06_05_04_03);
        pulse(1'b1, 1'b0, 56'h09_08_07_06_05_04_03);
        wait_idle("after_reset");

        repeat (30) @(negedge Clock_in);
        chk("leftover_expected", exp_acc.size() + exp_img.size() + exp_wd, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
